// File: rtl/opb_register_bank.sv
// rtl/opb_register_bank.sv - OPB slave bank of 32-bit software registers
// Read/write control registers and read-only status snapshots behind one address window.
module opb_register_bank #(
   parameter logic [31:0]              C_BASEADDR   = 32'h01000800,
   parameter logic [31:0]              C_HIGHADDR   = 32'h010008FF,
   parameter int                       C_OPB_AWIDTH = 32,
   parameter int                       C_OPB_DWIDTH = 32,
   parameter int                       C_NUM_REGS   = 8,
   parameter logic [63:0]              C_RO_MASK    = '0,
   parameter logic [C_NUM_REGS*32-1:0] C_RST_VAL    = '0,
   parameter                           C_FAMILY     = "virtex5"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst_n,
   input  logic [0:31]                OPB_ABus,
   input  logic [0:3]                 OPB_BE,
   input  logic [0:31]                OPB_DBus,
   input  logic                       OPB_RNW,
   input  logic                       OPB_select,
   input  logic                       OPB_seqAddr,
   output logic [0:31]                Sl_DBus,
   output logic                       Sl_xferAck,
   output logic                       Sl_errAck,
   output logic                       Sl_retry,
   output logic                       Sl_toutSup,
   output logic [C_NUM_REGS*32-1:0]   user_data_out,
   input  logic [C_NUM_REGS*32-1:0]   user_data_in,
   output logic [C_NUM_REGS-1:0]      user_wr_stb,
   output logic [C_NUM_REGS-1:0]      user_rd_stb
);

   localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_t;

   state_t        state_q;
   state_t        state_d;

   logic [31:0]   abus;
   logic [31:0]   offset;
   logic [31:0]   widx;
   logic          hit;
   logic          idx_ok;
   logic [IW-1:0] idx_new;
   logic [31:0]   rd_word;

   logic [IW-1:0] idx_q;
   logic          ok_q;
   logic          rnw_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;

   logic          do_latch;
   logic          wr_fire;
   logic          rd_fire;
   logic          is_ro;

   logic [31:0]   regs_q [C_NUM_REGS];

   logic          unused_inputs;

   // OPB bit 0 is the MSB, so a plain vector copy gives the numeric register view.
   assign abus    = OPB_ABus;
   assign offset  = abus - C_BASEADDR;
   assign widx    = offset >> 2;
   assign hit     = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign idx_ok  = widx < 32'(C_NUM_REGS);
   assign idx_new = widx[IW-1:0];
   assign is_ro   = C_RO_MASK[idx_q];

   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign unused_inputs = OPB_seqAddr;

   always_comb begin
      rd_word = '0;
      if (idx_ok) begin
         if (C_RO_MASK[idx_new])
            rd_word = user_data_in[32*idx_new +: 32];
         else
            rd_word = regs_q[idx_new];
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // A dropped select during ACK is an abort: no ack, no data, no side effects.
   always_comb begin
      state_d    = state_q;
      do_latch   = 1'b0;
      wr_fire    = 1'b0;
      rd_fire    = 1'b0;
      Sl_xferAck = 1'b0;
      Sl_DBus    = '0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               state_d  = S_ACK;
               do_latch = 1'b1;
            end
         end
         S_ACK: begin
            state_d = S_GAP;
            if (OPB_select) begin
               Sl_xferAck = 1'b1;
               if (rnw_q)
                  Sl_DBus = rdata_q;
               wr_fire = !rnw_q && ok_q && !is_ro;
               rd_fire = rnw_q && ok_q && is_ro;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         idx_q   <= '0;
         ok_q    <= 1'b0;
         rnw_q   <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (do_latch) begin
         idx_q   <= idx_new;
         ok_q    <= idx_ok;
         rnw_q   <= OPB_RNW;
         be_q    <= OPB_BE;
         wdata_q <= OPB_DBus;
         rdata_q <= rd_word;
      end
   end

   // be_q[j] enables register byte j; OPB_BE[0] landed in be_q[3] (bits 31:24).
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int i = 0; i < C_NUM_REGS; i++)
            regs_q[i] <= C_RST_VAL[32*i +: 32];
      end else if (wr_fire) begin
         for (int j = 0; j < 4; j++)
            if (be_q[j])
               regs_q[idx_q][8*j +: 8] <= wdata_q[8*j +: 8];
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         user_wr_stb <= '0;
         user_rd_stb <= '0;
      end else begin
         user_wr_stb <= '0;
         user_rd_stb <= '0;
         if (wr_fire)
            user_wr_stb[idx_q] <= 1'b1;
         if (rd_fire)
            user_rd_stb[idx_q] <= 1'b1;
      end
   end

   for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
      assign user_data_out[32*i +: 32] = C_RO_MASK[i] ? 32'h0 : regs_q[i];
   end

endmodule
